boot_controller: RTL and testbench
==================================

# boot_controller

Sequences the 4-bit CPU between program loading and execution and arbitrates the single 8-bit program memory between a host loader and CPU instruction fetch. The controller holds the CPU in reset while a host streams program bytes into memory over a valid/ready handshake. It then releases the CPU and routes memory read data onto the CPU's D_BUS. It sits between the CPU top level, the program memory and the host/debug port.

## Interface
Parameters:
- ADDR_W, 12, program memory address width; matches CPU `address`.
- DEPTH, 4096, program memory size in bytes; must be ≤ 2^ADDR_W.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- host_start  in  1  begin (or restart) a program load.
- host_valid  in  1  host_data holds a valid program byte.
- host_data  in  8  program byte.
- host_last  in  1  qualifies host_valid; marks the final byte of the program.
- host_ready  out  1  controller accepts a byte this cycle.
- cpu_address  in  ADDR_W  CPU fetch address.
- cpu_reset  out  1  drives the CPU `reset`; high holds the CPU in reset.
- d_bus  out  8  drives the CPU `D_BUS`.
- mem_addr  out  ADDR_W  program memory address.
- mem_wdata  out  8  program memory write data.
- mem_we  out  1  program memory write strobe; write occurs on the clock edge.
- mem_rdata  in  8  program memory asynchronous read data.
- loaded_count  out  ADDR_W+1  number of bytes accepted in the current or last load.
- checksum  out  8  mod-256 sum of the bytes accepted in the current or last load.
- error  out  1  load overflowed DEPTH.

## Operation
- States: IDLE, LOAD, RELEASE, RUN, ERROR. Reset enters IDLE.
- Transitions out of IDLE, LOAD, RUN and ERROR:
  - host_start=1 → LOAD. This clears the write pointer, loaded_count, checksum and error.
  - host_start has priority over every other event.
- LOAD:
  - host_ready=1.
  - A byte is accepted when host_valid=1 and host_start=0.
  - On acceptance: mem_we=1, mem_addr=pointer, mem_wdata=host_data. The pointer and loaded_count increment, and checksum += host_data (mod 256).
  - Accepted byte with host_last=1 → RELEASE.
  - Accepted byte at pointer DEPTH-1 with host_last=0 → ERROR. The byte is written; error is set.
- RELEASE: lasts one cycle, then → RUN unconditionally, unless host_start=1.
- RUN:
  - cpu_reset=0, mem_addr=cpu_address, d_bus=mem_rdata.
  - Remains in RUN until host_start or reset.
- ERROR: host_ready=0, cpu_reset=1, error=1. Left only via host_start or reset.
- Outside RUN: d_bus=8'h00 and cpu_reset=1.
- Outside LOAD: host_ready=0 and mem_we=0. mem_addr=cpu_address in every state except LOAD.
- A zero-length program is impossible: the first byte must carry host_last to finish the load.
- loaded_count and checksum hold their values after a load completes until the next host_start.

## Timing
- Reset values: cpu_reset=1, host_ready=0, mem_we=0, d_bus=8'h00, mem_addr=cpu_address, loaded_count=0, checksum=0, error=0.
- host_ready, mem_we and cpu_reset are decoded from the registered state only. The exception is mem_we, which is also gated by host_valid and host_start.
- Byte throughput: one byte per cycle with host_valid held high.
- Release latency:
  - Last byte accepted at edge E → RELEASE during cycle E..E+1.
  - RUN from edge E+1; cpu_reset falls after edge E+1.
  - The CPU's first fetch edge is E+2.
- host_start sampled at edge S → LOAD from S. host_ready is high in the cycle after S. cpu_reset is high after S, even from RUN, so the CPU restarts.
- host_start and host_valid both high in LOAD: the restart wins and no write occurs.
- Asynchronous reset mid-load: returns to IDLE immediately, mem_we drops, and counters clear.

## Test plan
- Reset, then host_start, then 3 bytes 0x12, 0x34, 0x56 with the last flagged: writes to addr 0..2; loaded_count=3; checksum=0x9C; cpu_reset low 2 edges after the last byte; d_bus follows mem_rdata at cpu_address.
- Host_valid toggling every other cycle during LOAD: only valid cycles write; addresses stay contiguous; checksum is correct.
- With DEPTH=4, 5 bytes and no host_last: 4 writes (addr 0..3), ERROR, error=1, host_ready=0, cpu_reset=1; then host_start → LOAD with error=0 and count=0.
- In RUN, host_start: cpu_reset rises after the edge; reload of a single byte 0xFF with last → count=1, checksum=0xFF, RUN again.
- host_start and host_valid in the same LOAD cycle: no mem_we; pointer=0 after the edge.
- Asynchronous reset asserted mid-load between edges: outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/boot_controller.sv
// Sequences CPU reset around a host program load and arbitrates the single program
// memory port between the host loader and CPU instruction fetch.
module boot_controller #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_start,
    input  logic              host_valid,
    input  logic [7:0]        host_data,
    input  logic              host_last,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] cpu_address,
    output logic              cpu_reset,
    output logic [7:0]        d_bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W:0]   loaded_count,
    output logic [7:0]        checksum,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN,
        ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pointer;
    logic              accept;

    // A restart request always beats a byte offered in the same cycle.
    assign accept = (state == LOAD) && host_valid && !host_start;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (host_start) begin
            next_state = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (host_last) begin
                            next_state = RELEASE;
                        end else if (pointer == LAST_ADDR) begin
                            next_state = ERROR;
                        end
                    end
                end
                RELEASE: next_state = RUN;
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pointer      <= '0;
            loaded_count <= '0;
            checksum     <= '0;
            error        <= 1'b0;
        end else if (host_start) begin
            pointer      <= '0;
            loaded_count <= '0;
            checksum     <= '0;
            error        <= 1'b0;
        end else if (accept) begin
            pointer      <= pointer + 1'b1;
            loaded_count <= loaded_count + 1'b1;
            checksum     <= checksum + host_data;
            if (!host_last && pointer == LAST_ADDR) begin
                error <= 1'b1;
            end
        end
    end

    // Memory port belongs to the loader only while loading; otherwise the CPU fetches.
    always_comb begin
        host_ready = 1'b0;
        cpu_reset  = 1'b1;
        d_bus      = 8'h00;
        mem_addr   = cpu_address;
        mem_wdata  = host_data;
        mem_we     = 1'b0;
        case (state)
            LOAD: begin
                host_ready = 1'b1;
                mem_addr   = pointer;
                mem_we     = accept;
            end
            RUN: begin
                cpu_reset = 1'b0;
                d_bus     = mem_rdata;
            end
            default: begin
                host_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_controller.sv
// Scoreboard bench for boot_controller: expected memory writes are queued as bytes are
// offered and retired by a monitor that inspects the memory port every cycle.
module tb_boot_controller;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } write_t;

    logic              clock;
    logic              reset;
    logic              host_start;
    logic              host_valid;
    logic [7:0]        host_data;
    logic              host_last;
    logic              host_ready;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_reset;
    logic [7:0]        d_bus;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;
    logic [ADDR_W:0]   loaded_count;
    logic [7:0]        checksum;
    logic              error;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    write_t            exp_q [$];
    logic [ADDR_W-1:0] exp_ptr;
    int                exp_count;
    logic [7:0]        exp_sum;
    int                compared;
    int                mismatched;

    boot_controller #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .host_start   (host_start),
        .host_valid   (host_valid),
        .host_data    (host_data),
        .host_last    (host_last),
        .host_ready   (host_ready),
        .cpu_address  (cpu_address),
        .cpu_reset    (cpu_reset),
        .d_bus        (d_bus),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .loaded_count (loaded_count),
        .checksum     (checksum),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    // Retire one queued write per cycle; any write with an empty queue is unexpected.
    always @(negedge clock) begin
        if (!reset) begin
            compared++;
            if (exp_q.size() > 0) begin
                write_t e;
                e = exp_q.pop_front();
                if (mem_we !== 1'b1 || mem_addr !== e.addr || mem_wdata !== e.data) begin
                    mismatched++;
                    $display("[TB] FAIL mem_write: got we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                             mem_we, mem_addr, mem_wdata, e.addr, e.data);
                end
            end else if (mem_we !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_write: got we=%b addr=%h data=%h, expected we=0",
                         mem_we, mem_addr, mem_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        host_start = 1'b1;
        host_valid = 1'b0;
        step();
        host_start = 1'b0;
        exp_ptr    = '0;
        exp_count  = 0;
        exp_sum    = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic last);
        write_t w;
        host_valid = 1'b1;
        host_data  = data;
        host_last  = last;
        w.addr = exp_ptr;
        w.data = data;
        exp_q.push_back(w);
        exp_ptr   = exp_ptr + 1'b1;
        exp_count = exp_count + 1;
        exp_sum   = exp_sum + data;
        step();
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic test_reset();
        cpu_address = 4'h5;
        #1;
        compared++;
        if (cpu_reset !== 1'b1 || host_ready !== 1'b0 || mem_we !== 1'b0 || d_bus !== 8'h00 ||
            mem_addr !== 4'h5 || loaded_count !== '0 || checksum !== 8'h00 || error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_values: got cr=%b hr=%b we=%b d=%h ma=%h cnt=%0d cs=%h err=%b, expected 1 0 0 00 5 0 00 0",
                     cpu_reset, host_ready, mem_we, d_bus, mem_addr, loaded_count, checksum, error);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_load();
        cpu_address = 4'h0;
        do_start();
        compared++;
        if (host_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL start_ready: got hr=%b cr=%b, expected hr=1 cr=1", host_ready, cpu_reset);
        end
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b1);
        compared++;
        if (cpu_reset !== 1'b1 || host_ready !== 1'b0 || loaded_count !== 5'd3 || checksum !== 8'h9C) begin
            mismatched++;
            $display("[TB] FAIL basic_release: got cr=%b hr=%b cnt=%0d cs=%h, expected cr=1 hr=0 cnt=3 cs=9c",
                     cpu_reset, host_ready, loaded_count, checksum);
        end
        step();
        compared++;
        if (cpu_reset !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_run: got cpu_reset=%b, expected 0", cpu_reset);
        end
        cpu_address = 4'h1;
        #1;
        compared++;
        if (d_bus !== 8'h34 || mem_addr !== 4'h1) begin
            mismatched++;
            $display("[TB] FAIL fetch_1: got d_bus=%h mem_addr=%h, expected 34 1", d_bus, mem_addr);
        end
        cpu_address = 4'h2;
        #1;
        compared++;
        if (d_bus !== 8'h56) begin
            mismatched++;
            $display("[TB] FAIL fetch_2: got d_bus=%h, expected 56", d_bus);
        end
        step();
    endtask

    task automatic test_toggle_valid();
        do_start();
        compared++;
        if (cpu_reset !== 1'b1 || loaded_count !== '0) begin
            mismatched++;
            $display("[TB] FAIL toggle_start: got cr=%b cnt=%0d, expected cr=1 cnt=0", cpu_reset, loaded_count);
        end
        send_byte(8'hA1, 1'b0);
        step();
        send_byte(8'hB2, 1'b0);
        step();
        send_byte(8'hC3, 1'b1);
        compared++;
        if (loaded_count !== 5'(exp_count) || checksum !== exp_sum || exp_sum !== 8'h16) begin
            mismatched++;
            $display("[TB] FAIL toggle_totals: got cnt=%0d cs=%h, expected cnt=%0d cs=%h",
                     loaded_count, checksum, exp_count, exp_sum);
        end
        step();
        step();
    endtask

    task automatic test_overflow();
        do_start();
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h40, 1'b0);
        compared++;
        if (error !== 1'b1 || host_ready !== 1'b0 || cpu_reset !== 1'b1 || loaded_count !== 5'd4) begin
            mismatched++;
            $display("[TB] FAIL overflow_enter: got err=%b hr=%b cr=%b cnt=%0d, expected 1 0 1 4",
                     error, host_ready, cpu_reset, loaded_count);
        end
        host_valid = 1'b1;
        host_data  = 8'h50;
        step();
        host_valid = 1'b0;
        compared++;
        if (error !== 1'b1 || loaded_count !== 5'd4 || checksum !== 8'hA0) begin
            mismatched++;
            $display("[TB] FAIL overflow_hold: got err=%b cnt=%0d cs=%h, expected 1 4 a0",
                     error, loaded_count, checksum);
        end
        do_start();
        compared++;
        if (error !== 1'b0 || loaded_count !== '0 || host_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL overflow_restart: got err=%b cnt=%0d hr=%b, expected 0 0 1",
                     error, loaded_count, host_ready);
        end
    endtask

    task automatic test_restart_in_run();
        send_byte(8'h77, 1'b1);
        step();
        compared++;
        if (cpu_reset !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL restart_pre_run: got cpu_reset=%b, expected 0", cpu_reset);
        end
        do_start();
        compared++;
        if (cpu_reset !== 1'b1 || host_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL restart_cpu_reset: got cr=%b hr=%b, expected 1 1", cpu_reset, host_ready);
        end
        send_byte(8'hFF, 1'b1);
        compared++;
        if (loaded_count !== 5'd1 || checksum !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL restart_totals: got cnt=%0d cs=%h, expected 1 ff", loaded_count, checksum);
        end
        step();
        cpu_address = 4'h0;
        #1;
        compared++;
        if (cpu_reset !== 1'b0 || d_bus !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL restart_run: got cr=%b d_bus=%h, expected 0 ff", cpu_reset, d_bus);
        end
        step();
    endtask

    task automatic test_start_with_valid();
        do_start();
        send_byte(8'h3C, 1'b0);
        host_start = 1'b1;
        host_valid = 1'b1;
        host_data  = 8'hEE;
        step();
        host_start = 1'b0;
        host_valid = 1'b0;
        exp_ptr    = '0;
        exp_count  = 0;
        exp_sum    = 8'h00;
        compared++;
        if (loaded_count !== '0 || checksum !== 8'h00 || host_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL start_valid_clear: got cnt=%0d cs=%h hr=%b, expected 0 00 1",
                     loaded_count, checksum, host_ready);
        end
        send_byte(8'h5A, 1'b1);
        step();
        step();
    endtask

    task automatic test_async_reset();
        do_start();
        send_byte(8'h11, 1'b0);
        host_valid = 1'b1;
        host_data  = 8'h22;
        #1;
        compared++;
        if (mem_we !== 1'b1 || loaded_count !== 5'd1) begin
            mismatched++;
            $display("[TB] FAIL async_pre: got we=%b cnt=%0d, expected 1 1", mem_we, loaded_count);
        end
        reset = 1'b1;
        #1;
        compared++;
        if (mem_we !== 1'b0 || cpu_reset !== 1'b1 || host_ready !== 1'b0 || loaded_count !== '0 ||
            checksum !== 8'h00 || mem_addr !== cpu_address) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got we=%b cr=%b hr=%b cnt=%0d cs=%h ma=%h, expected 0 1 0 0 00 %h",
                     mem_we, cpu_reset, host_ready, loaded_count, checksum, mem_addr, cpu_address);
        end
        host_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        reset       = 1'b1;
        host_start  = 1'b0;
        host_valid  = 1'b0;
        host_data   = 8'h00;
        host_last   = 1'b0;
        cpu_address = '0;
        exp_ptr     = '0;
        exp_count   = 0;
        exp_sum     = 8'h00;
        compared    = 0;
        mismatched  = 0;

        test_reset();
        test_basic_load();
        test_toggle_valid();
        test_overflow();
        test_restart_in_run();
        test_start_with_valid();
        test_async_reset();

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending writes, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
